// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EXE operand and control fields in, pipeline enables,
// flushes and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned ASIZE = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [ASIZE-1:0] id_rs1;
    logic [ASIZE-1:0] id_rs2;
    logic             id_uses_rs2;
    logic [ASIZE-1:0] exe_waddr;
    logic             exe_wen;
    logic             exe_memtoreg;
    logic             exe_branch;
    logic             exe_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             id_exe_en;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, exe_waddr, exe_wen, exe_memtoreg,
               exe_branch, exe_taken, mem_busy,
        input  pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, exe_waddr, exe_wen, exe_memtoreg,
               exe_branch, exe_taken, mem_busy,
        output pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes, with saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LU_PENALTY = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ASIZE      = 5
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    state_t           state;
    logic [1:0]       bcnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic lu_haz;
    logic br_tk;
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic if_id_flush;
    logic id_exe_flush;

    assign lu_haz = hz.exe_memtoreg & hz.exe_wen & (hz.exe_waddr != '0) & hz.id_valid &
                    ((hz.exe_waddr == hz.id_rs1) |
                     (hz.id_uses_rs2 & (hz.exe_waddr == hz.id_rs2)));
    assign br_tk  = hz.exe_branch & hz.exe_taken;

    // MEM_WAIT decodes exactly like RUN: busy freezes, otherwise normal RUN priority.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (!rst) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (hz.mem_busy) begin
            pc_en = 1'b0;
        end else if (state == LU_STALL) begin
            id_exe_en    = 1'b1;
            id_exe_flush = 1'b1;
        end else if (br_tk) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_exe_en    = 1'b1;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (lu_haz) begin
            id_exe_en    = 1'b1;
            id_exe_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_exe_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RUN;
            bcnt    <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            // With rst high, an IF/ID flush only comes from a taken branch.
            if (if_id_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
            case (state)
                LU_STALL: begin
                    if (!hz.mem_busy) begin
                        bcnt <= bcnt - 2'd1;
                        if (bcnt == 2'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    if (hz.mem_busy) begin
                        state <= MEM_WAIT;
                    end else if (br_tk) begin
                        state <= RUN;
                    end else if (lu_haz && (LU_PENALTY > 1)) begin
                        state <= LU_STALL;
                        bcnt  <= 2'(LU_PENALTY - 1);
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_exe_en    = id_exe_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_exe_flush = id_exe_flush;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three penalty/width builds driven in lockstep and checked
// every cycle against a bubbles-remaining reference model, plus directed scenarios.
module tb_pipe_hazard_ctrl;
    localparam int unsigned ASIZE = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             id_valid, id_uses_rs2, exe_wen, exe_memtoreg, exe_branch, exe_taken;
    logic             mem_busy;
    logic [ASIZE-1:0] id_rs1, id_rs2, exe_waddr;

    pipe_hazard_ctrl_if #(.ASIZE(ASIZE), .CNT_W(16)) if_p1 ();
    pipe_hazard_ctrl_if #(.ASIZE(ASIZE), .CNT_W(16)) if_p3 ();
    pipe_hazard_ctrl_if #(.ASIZE(ASIZE), .CNT_W(3))  if_p2 ();

    assign if_p1.id_valid = id_valid;         assign if_p3.id_valid = id_valid;
    assign if_p2.id_valid = id_valid;         assign if_p1.id_rs1 = id_rs1;
    assign if_p3.id_rs1 = id_rs1;             assign if_p2.id_rs1 = id_rs1;
    assign if_p1.id_rs2 = id_rs2;             assign if_p3.id_rs2 = id_rs2;
    assign if_p2.id_rs2 = id_rs2;             assign if_p1.id_uses_rs2 = id_uses_rs2;
    assign if_p3.id_uses_rs2 = id_uses_rs2;   assign if_p2.id_uses_rs2 = id_uses_rs2;
    assign if_p1.exe_waddr = exe_waddr;       assign if_p3.exe_waddr = exe_waddr;
    assign if_p2.exe_waddr = exe_waddr;       assign if_p1.exe_wen = exe_wen;
    assign if_p3.exe_wen = exe_wen;           assign if_p2.exe_wen = exe_wen;
    assign if_p1.exe_memtoreg = exe_memtoreg; assign if_p3.exe_memtoreg = exe_memtoreg;
    assign if_p2.exe_memtoreg = exe_memtoreg; assign if_p1.exe_branch = exe_branch;
    assign if_p3.exe_branch = exe_branch;     assign if_p2.exe_branch = exe_branch;
    assign if_p1.exe_taken = exe_taken;       assign if_p3.exe_taken = exe_taken;
    assign if_p2.exe_taken = exe_taken;       assign if_p1.mem_busy = mem_busy;
    assign if_p3.mem_busy = mem_busy;         assign if_p2.mem_busy = mem_busy;

    pipe_hazard_ctrl #(.LU_PENALTY(1), .CNT_W(16), .ASIZE(ASIZE)) u_p1 (
        .clk(clk), .rst(rst), .hz(if_p1.slave)
    );
    pipe_hazard_ctrl #(.LU_PENALTY(3), .CNT_W(16), .ASIZE(ASIZE)) u_p3 (
        .clk(clk), .rst(rst), .hz(if_p3.slave)
    );
    pipe_hazard_ctrl #(.LU_PENALTY(2), .CNT_W(3), .ASIZE(ASIZE)) u_p2 (
        .clk(clk), .rst(rst), .hz(if_p2.slave)
    );

    // Index 0: penalty 1, index 1: penalty 3, index 2: penalty 2 with 3-bit counters.
    logic [4:0]  obs_ctl [3];
    logic [15:0] obs_st  [3];
    logic [15:0] obs_fl  [3];
    always_comb begin
        obs_ctl[0] = {if_p1.pc_en, if_p1.if_id_en, if_p1.id_exe_en, if_p1.if_id_flush,
                      if_p1.id_exe_flush};
        obs_ctl[1] = {if_p3.pc_en, if_p3.if_id_en, if_p3.id_exe_en, if_p3.if_id_flush,
                      if_p3.id_exe_flush};
        obs_ctl[2] = {if_p2.pc_en, if_p2.if_id_en, if_p2.id_exe_en, if_p2.if_id_flush,
                      if_p2.id_exe_flush};
        obs_st[0]  = if_p1.stall_cnt;
        obs_st[1]  = if_p3.stall_cnt;
        obs_st[2]  = {13'd0, if_p2.stall_cnt};
        obs_fl[0]  = if_p1.flush_cnt;
        obs_fl[1]  = if_p3.flush_cnt;
        obs_fl[2]  = {13'd0, if_p2.flush_cnt};
    end

    int pen  [3] = '{1, 3, 2};
    int maxc [3] = '{65535, 65535, 7};
    int rem     [3];
    int m_stall [3];
    int m_flush [3];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input int d, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s (penalty %0d) observed=%h expected=%h", tag, pen[d], obs, exp);
        end
    endtask

    // One clock: compare outputs at negedge against the model, then advance it.
    task automatic cycle();
        logic       lu, br;
        logic [4:0] exp, mask;
        int         nrem;
        bit         brk;
        @(negedge clk);
        lu = exe_memtoreg && exe_wen && (exe_waddr != 0) && id_valid &&
             ((exe_waddr == id_rs1) || (id_uses_rs2 && (exe_waddr == id_rs2)));
        br = exe_branch && exe_taken;
        for (int d = 0; d < 3; d++) begin
            brk  = 1'b0;
            nrem = 0;
            if (!rst) begin
                exp = 5'b00011; mask = 5'b11111;
            end else if (mem_busy) begin
                exp = 5'b00000; mask = 5'b11111; nrem = rem[d];
            end else if (rem[d] > 0) begin
                exp = 5'b00001; mask = 5'b11011; nrem = rem[d] - 1;
            end else if (br) begin
                exp = 5'b11111; mask = 5'b10111; brk = 1'b1;
            end else if (lu) begin
                exp = 5'b00001; mask = 5'b11011; nrem = pen[d] - 1;
            end else begin
                exp = 5'b11100; mask = 5'b11111;
            end
            check("ctl", d, 16'(obs_ctl[d] & mask), 16'(exp & mask));
            check("stall_cnt", d, obs_st[d], 16'(m_stall[d]));
            check("flush_cnt", d, obs_fl[d], 16'(m_flush[d]));
            if (!rst) begin
                rem[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
            end else begin
                if (!exp[4] && m_stall[d] < maxc[d]) m_stall[d]++;
                if (brk && m_flush[d] < maxc[d]) m_flush[d]++;
                rem[d] = nrem;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic nop();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b1;
        exe_waddr = 5'd0; exe_wen = 1'b0; exe_memtoreg = 1'b0;
        exe_branch = 1'b0; exe_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic hazard();
        nop();
        exe_memtoreg = 1'b1; exe_wen = 1'b1; exe_waddr = 5'd5; id_rs1 = 5'd5;
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rem[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
        end
        nop();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        check("reset_stall", 1, obs_st[1], 16'd0);
        check("reset_flush", 1, obs_fl[1], 16'd0);

        // Single load-use hazard: one bubble at penalty 1, three at penalty 3.
        hazard(); cycle(); nop(); run(4);
        check("lu_p1_stall", 0, obs_st[0], 16'd1);
        check("lu_p3_stall", 1, obs_st[1], 16'd3);

        // Immediate form ignores rs2; register form sees it.
        do_reset(); hazard(); id_rs1 = 5'd2; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        cycle(); nop(); run(3);
        check("imm_no_stall", 1, obs_st[1], 16'd0);
        do_reset(); hazard(); id_rs1 = 5'd2; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        cycle(); nop(); run(3);
        check("rs2_stall", 1, obs_st[1], 16'd3);

        // Destination x0 never stalls.
        do_reset(); hazard(); exe_waddr = 5'd0; id_rs1 = 5'd0;
        cycle(); nop(); run(3);
        check("x0_no_stall", 1, obs_st[1], 16'd0);

        // Branch and load-use together: branch only.
        do_reset(); hazard(); exe_branch = 1'b1; exe_taken = 1'b1;
        cycle(); nop(); run(3);
        check("br_lu_flush", 1, obs_fl[1], 16'd1);
        check("br_lu_stall", 1, obs_st[1], 16'd0);
        check("br_lu_stall_p1", 0, obs_st[0], 16'd0);

        // Memory wait in the middle of the penalty-3 stall.
        do_reset(); hazard(); cycle(); nop(); cycle();
        mem_busy = 1'b1; run(4); mem_busy = 1'b0; run(4);
        check("memwait_stall", 1, obs_st[1], 16'd7);

        // Reset while stalled; next cycle is a plain RUN cycle.
        do_reset(); hazard(); cycle(); nop(); cycle();
        rst = 1'b0; cycle(); rst = 1'b1;
        check("rst_stall_cnt", 1, obs_st[1], 16'd0);
        #1;
        check("post_rst_run", 1, 16'(obs_ctl[1]), 16'h1C);
        run(2);

        // Flush counter saturation on the 3-bit build.
        do_reset(); exe_branch = 1'b1; exe_taken = 1'b1; run(10); nop(); cycle();
        check("flush_sat_w3", 2, obs_fl[2], 16'd7);
        check("flush_cnt_10", 0, obs_fl[0], 16'd10);

        // Randomized traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 63) != 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            exe_waddr    = 5'($urandom_range(0, 3));
            exe_wen      = ($urandom_range(0, 3) != 0);
            exe_memtoreg = ($urandom_range(0, 1) != 0);
            exe_branch   = ($urandom_range(0, 3) == 0);
            exe_taken    = 1'($urandom_range(0, 1));
            mem_busy     = ($urandom_range(0, 5) == 0);
            cycle();
        end
        rst = 1'b1;

        // Stall counter saturation at 16 bits.
        do_reset(); mem_busy = 1'b1; run(65540); mem_busy = 1'b0; run(2);
        check("stall_sat_p1", 0, obs_st[0], 16'hFFFF);
        check("stall_sat_p3", 1, obs_st[1], 16'hFFFF);
        check("stall_sat_w3", 2, obs_st[2], 16'd7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter LU_PENALTY, default 1, load-use bubble count (legal 1..3; 2-3 for builds without EXE forwarding).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL take widths ASIZE and ISIZE from define.v.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low; reset is applied on a rising clk edge when rst==0.
REQ-006 Port id_valid  input  1  the ID stage holds a real instruction.
REQ-007 Port id_rs1  input  ASIZE  first source register of the ID instruction.
REQ-008 Port id_rs2  input  ASIZE  second source register of the ID instruction.
REQ-009 Port id_uses_rs2  input  1  the ID instruction reads id_rs2; 0 for immediate forms.
REQ-010 Port exe_waddr  input  ASIZE  destination register held in the ID/EXE register.
REQ-011 Port exe_wen, exe_memtoreg, exe_branch  input  1 each  control bits held in the ID/EXE register.
REQ-012 Port exe_taken  input  1  the branch in EXE resolved taken (ALU zero result).
REQ-013 Port mem_busy  input  1  data memory is not ready this cycle.
REQ-014 Port pc_en, if_id_en, id_exe_en  output  1 each  load enables for the PC, IF/ID and ID/EXE registers.
REQ-015 Port if_id_flush, id_exe_flush  output  1 each  clear (bubble insert) for IF/ID and ID/EXE; a flush overrides its enable.
REQ-016 Port stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 SHALL implement three states: RUN, LU_STALL and MEM_WAIT, plus a 2-bit bubble down-counter bcnt.
REQ-018 Enables and flushes SHALL be combinational from state and inputs; state, bcnt and the counters SHALL be registered.
REQ-019 Hazard definition: lu_haz = exe_memtoreg & exe_wen & (exe_waddr!=0) & id_valid & (exe_waddr==id_rs1 | (id_uses_rs2 & exe_waddr==id_rs2)).
REQ-020 Branch definition: br_tk = exe_branch & exe_taken.
REQ-021 In RUN, priority SHALL be mem_busy, then br_tk, then lu_haz, then normal.
REQ-022 RUN with mem_busy: all enables and flushes 0; next state MEM_WAIT.
REQ-023 MEM_WAIT: all enables and flushes 0 for as long as mem_busy=1; the first cycle with mem_busy=0 behaves as a RUN cycle, with the same priority and transitions.
REQ-024 RUN with br_tk: pc_en=1, if_id_flush=1, id_exe_flush=1, id_exe_en=1; flush_cnt increments; next state RUN.
REQ-025 RUN with lu_haz: pc_en=0, if_id_en=0, id_exe_flush=1 (first bubble); if LU_PENALTY==1, next state RUN; otherwise next state LU_STALL with bcnt=LU_PENALTY-1.
REQ-026 LU_STALL: pc_en=0, if_id_en=0, id_exe_flush=1, bcnt decrements; the state exits to RUN on the cycle bcnt==1.
REQ-027 LU_STALL with mem_busy=1: all enables and flushes 0; bcnt and state hold.
REQ-028 br_tk and lu_haz SHALL be ignored in LU_STALL, because EXE holds a bubble.
REQ-029 Normal RUN: all enables 1, all flushes 0.
REQ-030 stall_cnt SHALL increment on every post-reset cycle with pc_en=0.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 The same-cycle combination of br_tk and lu_haz SHALL resolve as branch only; flush_cnt increments and stall_cnt does not.

Reset
REQ-033 A rising edge with rst==0 SHALL set the state to RUN, bcnt=0, stall_cnt=0 and flush_cnt=0, overriding any in-progress stall or wait.
REQ-034 While rst==0: pc_en=0, if_id_en=0, id_exe_en=0, if_id_flush=1, id_exe_flush=1, so downstream pipeline registers clear.
REQ-035 The first cycle after rst returns to 1 SHALL be a RUN cycle.

Verification
REQ-036 Load-use: LU_PENALTY=1, exe_memtoreg=1, exe_wen=1, exe_waddr=5, id_rs1=5 -> exactly one cycle of pc_en=0, if_id_en=0, id_exe_flush=1; stall_cnt=1.
REQ-037 Penalty and immediate form: LU_PENALTY=3 with the REQ-036 hazard -> three consecutive bubble cycles, then RUN; a repeat with id_rs2=5, id_uses_rs2=0, id_rs1=2 -> no stall.
REQ-038 Zero register: the hazard with exe_waddr=0=id_rs1 -> no stall; br_tk=1 together with lu_haz=1 -> single-cycle double flush, flush_cnt=1, stall_cnt unchanged.
REQ-039 Memory wait: mem_busy=1 for 4 cycles in the middle of LU_STALL (LU_PENALTY=3) -> enables 0 for those 4 cycles, then the remaining bubbles complete; stall_cnt=7.
REQ-040 Reset: rst=0 during LU_STALL -> next edge gives state RUN and counters 0, with both flushes =1 while rst=0.
REQ-041 Saturation: preload the counters, or run 65536 stall cycles -> stall_cnt holds at 0xFFFF.
